// File: rtl/fir0_decim.sv
// fir0_decim: 15-tap half-band decimate-by-2 filter, gain 4096.
// Four-stage pipeline, round half up and saturate on output.
module fir0_decim #(
  parameter int DATA_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  localparam int PW = DATA_W + 1;
  localparam int AW = DATA_W + 16;
  localparam logic signed [AW-1:0] SAT_HI = AW'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [AW-1:0] SAT_LO = ~SAT_HI;

  logic signed [DATA_W-1:0] x [15];
  logic                     phase;
  logic                     v1, v2, v3;
  logic signed [PW-1:0]     p0, p2, p4, p6;
  logic signed [DATA_W-1:0] c7;
  logic signed [AW-1:0]     acc;

  logic signed [AW-1:0] e0, e2, e4, e6, e7;
  logic signed [AW-1:0] m0, m2, m4, m6, m7;
  logic signed [AW-1:0] sum_c, rnd, y;

  function automatic logic signed [AW-1:0] ext(input logic signed [PW-1:0] p);
    return {{(AW-PW){p[PW-1]}}, p};
  endfunction

  // S1: delay line and phase; the token marks the second sample of each pair
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) x[i] <= '0;
      phase <= 1'b0;
      v1    <= 1'b0;
    end else begin
      v1 <= in_valid & phase;
      if (in_valid) begin
        x[0] <= in_data;
        for (int i = 1; i < 15; i++) x[i] <= x[i-1];
        phase <= ~phase;
      end
    end
  end

  // S2: symmetric pre-add of the non-zero tap pairs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p0 <= '0;
      p2 <= '0;
      p4 <= '0;
      p6 <= '0;
      c7 <= '0;
      v2 <= 1'b0;
    end else begin
      p0 <= {x[0][DATA_W-1], x[0]} + {x[14][DATA_W-1], x[14]};
      p2 <= {x[2][DATA_W-1], x[2]} + {x[12][DATA_W-1], x[12]};
      p4 <= {x[4][DATA_W-1], x[4]} + {x[10][DATA_W-1], x[10]};
      p6 <= {x[6][DATA_W-1], x[6]} + {x[8][DATA_W-1], x[8]};
      c7 <= x[7];
      v2 <= v1;
    end
  end

  // Constant multiplies: 6, 54 = 32+16+4+2, 254 = 256-2, 1230 = 1024+128+64+8+4+2
  always_comb begin
    e0 = ext(p0);
    e2 = ext(p2);
    e4 = ext(p4);
    e6 = ext(p6);
    e7 = {{(AW-DATA_W){c7[DATA_W-1]}}, c7};
    m0 = -((e0 <<< 2) + (e0 <<< 1));
    m2 = (e2 <<< 5) + (e2 <<< 4) + (e2 <<< 2) + (e2 <<< 1);
    m4 = (e4 <<< 1) - (e4 <<< 8);
    m6 = (e6 <<< 10) + (e6 <<< 7) + (e6 <<< 6)
       + (e6 <<< 3) + (e6 <<< 2) + (e6 <<< 1);
    m7 = e7 <<< 11;
    sum_c = m0 + m2 + m4 + m6 + m7;
  end

  // S3: full-precision accumulator
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      v3  <= 1'b0;
    end else begin
      acc <= sum_c;
      v3  <= v2;
    end
  end

  always_comb begin
    rnd = acc + AW'(2048);
    y   = rnd >>> 12;
  end

  // S4: round/saturate; out_data holds between strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= v3;
      if (v3) begin
        if (y > SAT_HI)      out_data <= SAT_HI[DATA_W-1:0];
        else if (y < SAT_LO) out_data <= SAT_LO[DATA_W-1:0];
        else                 out_data <= y[DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_fir0_decim.sv
// tb_fir0_decim: random/directed stimulus, reference model and
// queue scoreboard with a negedge monitor for fir0_decim.
module tb_fir0_decim;
  localparam int W = 14;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic [W-1:0] out_data;

  fir0_decim #(.DATA_W(W)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  int h[15] = '{-6, 0, 54, 0, -254, 0, 1230, 2048, 1230, 0, -254, 0, 54, 0, -6};
  int odd_ref[8] = '{-6, 54, -254, 1230, 1230, -254, 54, -6};
  int sat_seq[16] = '{0, -8192, 0, 8191, 0, -8192, 0, 8191,
                      8191, 8191, 0, -8192, 0, 8191, 0, -8192};
  int hist[15];
  bit ph;
  int exp_d[$];
  int exp_t[$];
  int got_q[$];
  int ref_q[$];
  int last_out = 0;
  int mon_d, mon_e, mon_t;

  task automatic check(string nm, int act, int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, act, req, cyc);
  endtask

  // Reference: direct convolution over the accepted-sample history
  task automatic model_accept(int d, int due);
    int acc;
    int y;
    for (int k = 14; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = d;
    if (ph) begin
      acc = 0;
      for (int k = 0; k < 15; k++) acc += h[k] * hist[k];
      y = (acc + 2048) >>> 12;
      if (y > 8191) y = 8191;
      if (y < -8192) y = -8192;
      exp_d.push_back(y);
      exp_t.push_back(due);
    end
    ph = ~ph;
  endtask

  task automatic send(bit v, int d);
    @(posedge clk);
    #1;
    in_valid = v;
    in_data = d[W-1:0];
    if (v) model_accept(d, cyc + 4);
  endtask

  task automatic idle(int n);
    repeat (n) send(1'b0, 0);
  endtask

  task automatic do_reset(int n);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_d.delete();
    exp_t.delete();
    for (int k = 0; k < 15; k++) hist[k] = 0;
    ph = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'($urandom % 2);
      in_data = W'($urandom);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      check("rst_valid", int'(out_valid), 0);
      check("rst_data", int'($signed(out_data)), 0);
      last_out = 0;
    end else if (out_valid) begin
      mon_d = int'($signed(out_data));
      if (exp_d.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        mon_e = exp_d.pop_front();
        mon_t = exp_t.pop_front();
        check("out_data", mon_d, mon_e);
        check("latency", cyc, mon_t);
      end
      got_q.push_back(mon_d);
      last_out = mon_d;
    end else begin
      check("hold", int'($signed(out_data)), last_out);
    end
  end

  initial begin
    int n_acc;
    bit v;
    #1 reset = 1'b1;
    do_reset(6);

    // odd-aligned impulse
    got_q.delete();
    send(1'b1, 0);
    send(1'b1, 4096);
    repeat (18) send(1'b1, 0);
    idle(6);
    check("odd_cnt", got_q.size(), 10);
    if (got_q.size() >= 10) begin
      for (int i = 0; i < 8; i++) check("odd_ref", got_q[i], odd_ref[i]);
      check("odd_tail", got_q[9], 0);
    end

    // even-aligned impulse
    do_reset(3);
    got_q.delete();
    send(1'b1, 4096);
    repeat (19) send(1'b1, 0);
    idle(6);
    check("even_cnt", got_q.size(), 10);
    if (got_q.size() >= 10) begin
      check("even_0", got_q[0], 0);
      check("even_3", got_q[3], 2048);
      check("even_4", got_q[4], 0);
    end

    // DC, continuous then gapped
    do_reset(2);
    got_q.delete();
    repeat (40) send(1'b1, 1000);
    idle(6);
    ref_q = got_q;
    check("dc_cnt", ref_q.size(), 20);
    do_reset(2);
    got_q.delete();
    n_acc = 0;
    for (int i = 0; i < 2000 && n_acc < 40; i++) begin
      v = 1'($urandom % 2);
      send(v, 1000);
      if (v) n_acc++;
    end
    idle(6);
    check("gap_cnt", got_q.size(), n_acc / 2);
    if (got_q.size() == 20 && ref_q.size() == 20) begin
      for (int i = 0; i < 20; i++) check("gap_eq", got_q[i], ref_q[i]);
      for (int i = 7; i < 20; i++) check("dc_val", got_q[i], 1000);
    end

    // saturation
    do_reset(2);
    got_q.delete();
    repeat (30) send(1'b1, 8191);
    idle(6);
    if (got_q.size() > 0) check("sat_hi", got_q[got_q.size()-1], 8191);
    else check("sat_hi_cnt", 0, 15);
    do_reset(2);
    got_q.delete();
    repeat (30) send(1'b1, -8192);
    idle(6);
    if (got_q.size() > 0) check("sat_lo", got_q[got_q.size()-1], -8192);
    else check("sat_lo_cnt", 0, 15);
    do_reset(2);
    got_q.delete();
    for (int i = 0; i < 16; i++) send(1'b1, sat_seq[i]);
    idle(6);
    check("seq_cnt", got_q.size(), 8);
    if (got_q.size() >= 8) check("seq_clip", got_q[7], 8191);

    // random samples against the model
    do_reset(2);
    repeat (300) send(1'($urandom % 4 != 0), int'($signed(W'($urandom))));
    idle(6);

    // reset one cycle after a triggering sample
    do_reset(2);
    send(1'b1, 0);
    send(1'b1, 500);
    got_q.delete();
    do_reset(2);
    idle(6);
    check("mid_rst_none", got_q.size(), 0);
    got_q.delete();
    send(1'b1, 0);
    send(1'b1, 4096);
    repeat (18) send(1'b1, 0);
    idle(6);
    check("post_cnt", got_q.size(), 10);
    if (got_q.size() >= 8)
      for (int i = 0; i < 8; i++) check("post_ref", got_q[i], odd_ref[i]);

    check("drain", exp_d.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
